// File: rtl/stack_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stack_unit : register-array operand stack with sticky ovf/udf flags   |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module stack_unit #(
  parameter int DATA_LEN  = 8,
  parameter int STK_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       stk_push,
  input  logic                       stk_pop,
  input  logic [DATA_LEN-1:0]        stk_data_in,
  output logic [DATA_LEN-1:0]        stk_data_out,
  output logic [DATA_LEN-1:0]        stk_data_nxt,
  output logic [$clog2(STK_DEPTH):0] stk_count,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       stk_ovf,
  output logic                       stk_udf
);

  localparam int            AW       = $clog2(STK_DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(STK_DEPTH);
  localparam logic [CW-1:0] TWO_CNT  = CW'(2);

  logic [DATA_LEN-1:0] mem_q [STK_DEPTH];
  logic [DATA_LEN-1:0] mem_d [STK_DEPTH];
  logic [CW-1:0]       sp_q, sp_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic                is_full, is_empty;
  logic [AW-1:0]       wr_idx, top_idx, nxt_idx;

  assign is_full  = (sp_q == FULL_CNT);
  assign is_empty = (sp_q == '0);
  // Index truncation is safe: each index is only used when it is in range.
  assign wr_idx   = AW'(sp_q);
  assign top_idx  = AW'(sp_q - 1'b1);
  assign nxt_idx  = AW'(sp_q - TWO_CNT);

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (en) begin
      case ({stk_push, stk_pop})
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_d[wr_idx] = stk_data_in;
            sp_d          = sp_q + 1'b1;
          end
        end
        2'b01: begin
          if (is_empty) udf_d = 1'b1;
          else          sp_d  = sp_q - 1'b1;
        end
        2'b11: begin
          // Replace-top: legal even when full, only an empty stack is an error.
          if (is_empty) udf_d = 1'b1;
          else          mem_d[top_idx] = stk_data_in;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign stk_data_out = is_empty        ? '0 : mem_q[top_idx];
  assign stk_data_nxt = (sp_q < TWO_CNT) ? '0 : mem_q[nxt_idx];
  assign stk_count    = sp_q;
  assign stk_full     = is_full;
  assign stk_empty    = is_empty;
  assign stk_ovf      = ovf_q;
  assign stk_udf      = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stack_unit : directed bench with queue-based stack reference model |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_stack_unit;

  localparam int DATA_LEN  = 8;
  localparam int STK_DEPTH = 16;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       en = 1'b0;
  logic                       stk_push = 1'b0;
  logic                       stk_pop = 1'b0;
  logic [DATA_LEN-1:0]        stk_data_in = '0;
  logic [DATA_LEN-1:0]        stk_data_out;
  logic [DATA_LEN-1:0]        stk_data_nxt;
  logic [$clog2(STK_DEPTH):0] stk_count;
  logic                       stk_full;
  logic                       stk_empty;
  logic                       stk_ovf;
  logic                       stk_udf;

  stack_unit #(.DATA_LEN(DATA_LEN), .STK_DEPTH(STK_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .stk_data_nxt (stk_data_nxt),
    .stk_count    (stk_count),
    .stk_full     (stk_full),
    .stk_empty    (stk_empty),
    .stk_ovf      (stk_ovf),
    .stk_udf      (stk_udf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue whose back is the top of stack.
  logic [DATA_LEN-1:0] m_q [$];
  bit                  m_ovf = 1'b0;
  bit                  m_udf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (en) begin
      if (stk_push && !stk_pop) begin
        if (m_q.size() == STK_DEPTH) m_ovf = 1'b1;
        else                         m_q.push_back(stk_data_in);
      end else if (stk_pop && !stk_push) begin
        if (m_q.size() == 0) m_udf = 1'b1;
        else                 void'(m_q.pop_back());
      end else if (stk_pop && stk_push) begin
        if (m_q.size() == 0) m_udf = 1'b1;
        else                 m_q[m_q.size()-1] = stk_data_in;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int n;
      n = m_q.size();
      chk("count", 32'(stk_count), 32'(n));
      chk("top",   32'(stk_data_out), (n >= 1) ? 32'(m_q[n-1]) : 32'd0);
      chk("nxt",   32'(stk_data_nxt), (n >= 2) ? 32'(m_q[n-2]) : 32'd0);
      chk("full",  32'(stk_full),  32'(n == STK_DEPTH));
      chk("empty", 32'(stk_empty), 32'(n == 0));
      chk("ovf",   32'(stk_ovf),   32'(m_ovf));
      chk("udf",   32'(stk_udf),   32'(m_udf));
    end
  end

  // One clock: drive at negedge, return just after the sampling edge.
  task automatic cyc(input logic r, input logic e, input logic pu, input logic po,
                     input logic [DATA_LEN-1:0] d);
    @(negedge clk);
    rst = r; en = e; stk_push = pu; stk_pop = po; stk_data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input logic [DATA_LEN-1:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic pop();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, '0);
  endtask

  task automatic push_pop(input logic [DATA_LEN-1:0] d);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out"},   32'(stk_data_out), 32'h0);
    chk({tag, "_nxt"},   32'(stk_data_nxt), 32'h0);
    chk({tag, "_count"}, 32'(stk_count),    32'd0);
    chk({tag, "_full"},  32'(stk_full),     32'd0);
    chk({tag, "_empty"}, 32'(stk_empty),    32'd1);
    chk({tag, "_ovf"},   32'(stk_ovf),      32'd0);
    chk({tag, "_udf"},   32'(stk_udf),      32'd0);
  endtask

  initial begin
    do_reset();
    chk_on = 1'b1;
    chk_reset_vals("rst");

    // Basic LIFO ordering
    push(8'h11); push(8'h22); push(8'h33);
    chk("t1_count", 32'(stk_count), 32'd3);
    chk("t1_top",   32'(stk_data_out), 32'h33);
    chk("t1_nxt",   32'(stk_data_nxt), 32'h22);
    pop(); pop();
    chk("t1_top2",   32'(stk_data_out), 32'h11);
    chk("t1_count2", 32'(stk_count), 32'd1);
    chk("t1_flags",  32'({stk_ovf, stk_udf}), 32'd0);

    // Fill, overflow, replace-top while full
    do_reset();
    for (int i = 1; i <= STK_DEPTH; i++) push(8'(i));
    chk("t2_full", 32'(stk_full), 32'd1);
    chk("t2_top",  32'(stk_data_out), 32'd16);
    chk("t2_nxt",  32'(stk_data_nxt), 32'd15);
    push(8'hAA);
    chk("t2_ovf",    32'(stk_ovf), 32'd1);
    chk("t2_count",  32'(stk_count), 32'd16);
    chk("t2_top_ov", 32'(stk_data_out), 32'd16);
    push_pop(8'h55);
    chk("t2_rep_top",   32'(stk_data_out), 32'h55);
    chk("t2_rep_count", 32'(stk_count), 32'd16);
    chk("t2_rep_ovf",   32'(stk_ovf), 32'd1);
    pop();
    chk("t2_after_pop", 32'(stk_data_out), 32'd15);

    // Underflow paths
    do_reset();
    pop();
    chk("t3_udf",   32'(stk_udf), 32'd1);
    chk("t3_empty", 32'(stk_empty), 32'd1);
    chk("t3_count", 32'(stk_count), 32'd0);
    push_pop(8'h44);
    chk("t3_pp_count", 32'(stk_count), 32'd0);
    chk("t3_pp_out",   32'(stk_data_out), 32'h0);
    push(8'h07);
    chk("t3_count1", 32'(stk_count), 32'd1);
    chk("t3_top",    32'(stk_data_out), 32'h07);
    chk("t3_udf_st", 32'(stk_udf), 32'd1);
    chk("t3_nxt",    32'(stk_data_nxt), 32'h0);

    // Replace top (ALU result write-back)
    do_reset();
    push(8'h10); push(8'h20); push_pop(8'h30);
    chk("t4_count", 32'(stk_count), 32'd2);
    chk("t4_top",   32'(stk_data_out), 32'h30);
    chk("t4_nxt",   32'(stk_data_nxt), 32'h10);

    // Enable gating
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hEF);
    chk("t5_count", 32'(stk_count), 32'd5);
    chk("t5_top",   32'(stk_data_out), 32'hC4);
    chk("t5_flags", 32'({stk_ovf, stk_udf}), 32'd0);
    pop();
    chk("t5_count4", 32'(stk_count), 32'd4);
    chk("t5_top4",   32'(stk_data_out), 32'hC3);
    // en=0 on an empty/full stack must not raise flags either
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("t5_no_udf", 32'(stk_udf), 32'd0);

    // Reset mid-sequence wins over a simultaneous push
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    for (int i = 5; i < STK_DEPTH; i++) push(8'(8'h50 + i));
    push(8'hAB);
    chk("t6_ovf", 32'(stk_ovf), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
    chk_reset_vals("t6_rst");
    push(8'h99);
    chk("t6_count", 32'(stk_count), 32'd1);
    chk("t6_top",   32'(stk_data_out), 32'h99);

    @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack that answers the push/pop requests issued by the execution core. The core drives `stk_push`/`stk_pop`/`stk_data_in` and consumes `stk_data_out`. This block owns the storage, the stack pointer, and the full/empty/error status. It sits beside the execution core at the top level and is the responder end of the core's stack interface.

## Interface
Parameters:
- `DATA_LEN`, 8: width of one stack entry.
- `STK_DEPTH`, 16: number of entries; power of two, ≥ 2.

Ports (`CW` = $clog2(STK_DEPTH)+1):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  global enable; when 0 all state holds and requests are ignored.
- `stk_push`  in  1  push request, sampled at rising edge.
- `stk_pop`  in  1  pop request, sampled at rising edge.
- `stk_data_in`  in  DATA_LEN  value to push (written by the core).
- `stk_data_out`  out  DATA_LEN  current top of stack; 0 when empty.
- `stk_data_nxt`  out  DATA_LEN  entry below top; 0 when fewer than 2 entries.
- `stk_count`  out  CW  number of valid entries, 0..STK_DEPTH.
- `stk_full`  out  1  `stk_count == STK_DEPTH`.
- `stk_empty`  out  1  `stk_count == 0`.
- `stk_ovf`  out  1  sticky overflow error.
- `stk_udf`  out  1  sticky underflow error.

## Operation
- Storage: register array `mem[0..STK_DEPTH-1]`. Pointer `sp` = `stk_count`. Top is `mem[sp-1]`; next is `mem[sp-2]`.
- Outputs are combinational from registered state only; there is no input-to-output combinational path.
- The following actions apply on a rising edge with `en`=1 and `rst`=0:
  - Push only, not full: `mem[sp]` ← `stk_data_in`; sp+1.
  - Push only, full: no write; sp unchanged; `stk_ovf` ← 1.
  - Pop only, not empty: sp−1. The popped value is the `stk_data_out` present before the edge. Memory is not cleared.
  - Pop only, empty: sp unchanged; `stk_udf` ← 1.
  - Push and pop together, not empty: replace top, i.e. `mem[sp-1]` ← `stk_data_in`; sp unchanged. This holds even when full, with no overflow.
  - Push and pop together, empty: no write; sp stays 0; `stk_udf` ← 1.
  - Neither: hold.
- With `en`=0: all state holds and the error flags do not set.
- `stk_ovf` and `stk_udf` are sticky. Only `rst` clears them.
- Any error case leaves the stored data and `sp` exactly unchanged.
- The pointer never wraps. It saturates at 0 and STK_DEPTH by the rules above.

## Timing
- Reset (`rst`=1 at an edge) has priority over `en` and all requests. It sets sp=0, `stk_ovf`=0, `stk_udf`=0. The array contents are don't-care.
- Output values after reset: `stk_data_out`=0, `stk_data_nxt`=0, `stk_count`=0, `stk_full`=0, `stk_empty`=1, `stk_ovf`=0, `stk_udf`=0.
- Reset asserted mid-sequence discards all entries at that edge. Any push or pop sampled on the same edge is ignored.
- Latency: every operation takes effect at the sampling edge. The new top, count, and flags are visible immediately after that edge, i.e. one cycle after the request is presented. Back-to-back operations on consecutive cycles are fully supported with no bubbles.
- A value pushed at edge N is poppable at edge N+1.
- No handshake or ready signal. The requester is responsible for consulting `stk_full`/`stk_empty`; violations are reported through the sticky flags.
- `stk_full` and `stk_empty` are derived from `stk_count`. They change in the same cycle as the count.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles → after the third edge: `stk_count`=3, `stk_data_out`=0x33, `stk_data_nxt`=0x22. Then pop twice → `stk_data_out`=0x11, `stk_count`=1, no flags set.
- Push STK_DEPTH values 1..16 → `stk_full`=1, top=16. Push 0xAA → `stk_ovf`=1, count stays 16, top stays 16. Then push+pop with 0x55 → top=0x55, count 16, `stk_ovf` still 1.
- From reset, pop → `stk_udf`=1, `stk_empty`=1, count 0. Push+pop on empty → count 0, `stk_data_out`=0. Then push 0x07 → count 1, top 0x07, `stk_udf` stays 1.
- Push 0x10, 0x20, then push+pop with 0x30 (ALU result replace) → count 2, top 0x30, nxt 0x10.
- Fill 5 entries, hold `en`=0 while driving push and pop for 4 cycles → count, top, and flags unchanged. Re-enable and pop → count 4.
- Fill 5 entries, set `stk_ovf` via a full stack, assert `rst` together with push → all outputs at reset values. The following push of 0x99 → count 1, top 0x99.
